uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Sequencing and arbitration controller in front of the UART transmitter. Two requesters each submit a 16-bit message, for example the 4-digit value shown on the LED driver. The block grants the transmitter round-robin and sends each message as two bytes, high byte first, using the transmitter's write/busy handshake. It detects a transmitter that never starts, and enforces an idle gap between messages so the receiver-side message buffer stays byte-aligned.

## Interface
- GAP_CYCLES, default 16: idle cycles inserted after each completed or aborted message (≥1).
- START_TIMEOUT, default 64: maximum cycles to wait for tx_busy to rise after a tx_wr pulse.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high.
- req  in  2  per-requester request. Held high until the matching ack.
- msg0  in  16  requester 0 message, sampled at grant.
- msg1  in  16  requester 1 message, sampled at grant.
- ack  out  2  one-cycle pulse per requester when its message finishes or aborts.
- err  out  1  one-cycle pulse, coincident with ack, when a message aborted on timeout.
- tx_data  out  8  byte to the transmitter. Stable from the tx_wr cycle until tx_busy falls.
- tx_wr  out  1  one-cycle write strobe to the transmitter.
- tx_busy  in  1  transmitter busy flag.
- active  out  1  high in every state except IDLE.

## Operation
- States: IDLE, STROBE, WAIT_START, WAIT_DONE, FINISH, GAP.
- IDLE
  - If any req is high, grant using round-robin: the requester not granted last wins when both are high.
  - last_grant resets to 1, so requester 0 wins the first contention.
  - On grant: latch the selected msg into msg_reg, record grant_id, clear byte_idx, go to STROBE.
- STROBE
  - tx_wr=1 for exactly one cycle.
  - tx_data = msg_reg[15:8] when byte_idx=0, msg_reg[7:0] when byte_idx=1.
  - Clear the timeout counter, go to WAIT_START.
- WAIT_START
  - tx_busy=1 → WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches START_TIMEOUT, set abort and go to FINISH.
- WAIT_DONE
  - tx_busy=0 and byte_idx=0 → set byte_idx=1, go to STROBE.
  - tx_busy=0 and byte_idx=1 → FINISH.
- FINISH
  - ack[grant_id]=1 for one cycle; err=abort.
  - Update last_grant=grant_id, clear abort, load the gap counter, go to GAP.
- GAP: count down GAP_CYCLES cycles, then go to IDLE. Requests are ignored during GAP.
- A requester dropping req mid-message has no effect. The latched message completes.
- An aborted message never sends its low byte.
- Reset mid-message: return to IDLE immediately. No ack, tx_wr low. The transmitter's own reset handles the partial frame.
- Counters
  - Timeout counter: $clog2(START_TIMEOUT+1) bits, saturating.
  - Gap counter: $clog2(GAP_CYCLES+1) bits.
  - No wrap-around in either.

## Timing
- Reset values
  - Outputs: ack=0, err=0, tx_wr=0, tx_data=0, active=0.
  - Internal: state=IDLE, last_grant=1.
- All outputs are registered.
- Cycle numbering
  - Request visible in IDLE at edge N → grant registered at N; STROBE, and therefore tx_wr, in cycle N+1.
  - High byte tx_wr follows the request by 1 cycle.
  - Low byte tx_wr comes 1 cycle after tx_busy is sampled low in WAIT_DONE.
  - ack comes 1 cycle after the final busy fall, or 1 cycle after the timeout count reaches START_TIMEOUT.
- Earliest next grant: FINISH + GAP_CYCLES + 1 cycles.
- Simultaneous events
  - A new req rising in the same cycle as another's ack is not granted until after GAP.
  - Both req high in IDLE → exactly one grant, per last_grant.

## Structure
- Shared package uart_pkg:
  - state enum encoding;
  - the 16-bit message width;
  - the high-byte-first byte-order constant, shared with the receive-side message buffer.
- One natural sub-module: uart_rr_arbiter2.
  - Combinational 2-way round-robin pick from req and last_grant.
  - Outputs grant_valid and grant_id.
- FSM, counters and datapath registers live in uart_tx_scheduler.

## Test plan
- Single request: reset, req=2'b01, msg0=16'hBEEF, transmitter model with busy 3 cycles after wr for 100 cycles.
  - tx_wr pulses carry 8'hBE then 8'hEF.
  - ack=2'b01 once, err=0, next grant no sooner than GAP_CYCLES later.
- Contention: req=2'b11 held, msg0=16'h1111, msg1=16'h2222.
  - Messages sent in order 11,11,22,22,11,11.
  - ack alternates 01,10,01.
- Timeout: tx_busy tied 0, req=2'b10.
  - One tx_wr with 8'h22.
  - After START_TIMEOUT cycles: ack=2'b10 and err=1 in the same cycle, no second tx_wr.
- Reset mid-message: assert reset during WAIT_DONE of the low byte.
  - Next cycle: all outputs at reset values, no ack.
  - Subsequent req=2'b01 served normally.
- Request withdrawal: drop req[0] one cycle after the grant, change msg0.
  - Both original bytes still sent, ack[0] pulses.
- Loopback with the receiver and message buffer, noise=0, msg0=16'h1234: LED driver message becomes 16'h1234.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART message definitions: scheduler state encoding, message geometry and byte order.
// The byte order is shared with the receive-side message buffer so both ends agree on framing.
package uart_pkg;

    localparam int MSG_W  = 16;
    localparam int BYTE_W = 8;

    // 1: the high byte goes on the wire first.
    localparam logic HIGH_BYTE_FIRST = 1'b1;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_STROBE     = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
    localparam logic [2:0] ST_FINISH     = 3'd4;
    localparam logic [2:0] ST_GAP        = 3'd5;

    function automatic logic [BYTE_W-1:0] msg_byte(input logic [MSG_W-1:0] msg, input logic idx);
        msg_byte = (idx == HIGH_BYTE_FIRST) ? msg[BYTE_W-1:0] : msg[MSG_W-1:BYTE_W];
    endfunction

endpackage

// File: rtl/uart_rr_arbiter2.sv
// Two-way round-robin pick: the requester not granted last wins a tie.
// Latency: combinational; backpressure: none, the caller decides when to use the pick.
module uart_rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sequencer sending each 16-bit request as two UART bytes, then an idle gap.
// Latency: tx_wr one cycle after grant; backpressure: waits on tx_busy, aborts if it never rises.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [MSG_W-1:0]  msg0,
    input  logic [MSG_W-1:0]  msg1,
    output logic [1:0]        ack,
    output logic              err,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_wr,
    input  logic              tx_busy,
    output logic              active
);

    localparam int TO_W  = $clog2(START_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic [2:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_id_q, grant_id_d;
    logic [MSG_W-1:0]  msg_q, msg_d;
    logic              byte_idx_q, byte_idx_d;
    logic              abort_q, abort_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [1:0]        ack_q, ack_d;
    logic              err_q, err_d;
    logic              tx_wr_q, tx_wr_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              active_q, active_d;

    logic arb_vld;
    logic arb_id;

    uart_rr_arbiter2 u_arb (
        .req         (req),
        .last_grant  (last_grant_q),
        .grant_valid (arb_vld),
        .grant_id    (arb_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        msg_d        = msg_q;
        byte_idx_d   = byte_idx_q;
        abort_d      = abort_q;
        to_cnt_d     = to_cnt_q;
        gap_d        = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    msg_d      = arb_id ? msg1 : msg0;
                    grant_id_d = arb_id;
                    byte_idx_d = 1'b0;
                    state_d    = ST_STROBE;
                end
            end
            ST_STROBE: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    if (to_cnt_q != TO_W'(START_TIMEOUT)) begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                    if (to_cnt_d == TO_W'(START_TIMEOUT)) begin
                        abort_d = 1'b1;
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (!byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        state_d    = ST_STROBE;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                last_grant_d = grant_id_q;
                abort_d      = 1'b0;
                gap_d        = GAP_W'(GAP_CYCLES);
                state_d      = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        tx_wr_d   = (state_d == ST_STROBE);
        tx_data_d = tx_data_q;
        if (state_d == ST_STROBE) begin
            tx_data_d = msg_byte(msg_d, byte_idx_d);
        end
        ack_d    = (state_d == ST_FINISH) ? (grant_id_q ? 2'b10 : 2'b01) : 2'b00;
        err_d    = (state_d == ST_FINISH) && abort_d;
        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            msg_q        <= '0;
            byte_idx_q   <= 1'b0;
            abort_q      <= 1'b0;
            to_cnt_q     <= '0;
            gap_q        <= '0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            tx_wr_q      <= 1'b0;
            tx_data_q    <= '0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            msg_q        <= msg_d;
            byte_idx_q   <= byte_idx_d;
            abort_q      <= abort_d;
            to_cnt_q     <= to_cnt_d;
            gap_q        <= gap_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            tx_wr_q      <= tx_wr_d;
            tx_data_q    <= tx_data_d;
            active_q     <= active_d;
        end
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign tx_wr   = tx_wr_q;
    assign tx_data = tx_data_q;
    assign active  = active_q;

endmodule
